frobenius_sumsq_sqrt: RTL and testbench

Streaming reduction stage directly upstream of the Frobenius-norm normalizer. Accepts one frame of N_ELEM signed fixed-point tensor elements, accumulates the exact sum of squares, then computes the integer (floor) square root sequentially. The resulting norm is presented on a valid/ready output for the normalizer, which divides each element by it.

---
 rtl/frobenius_sumsq_sqrt_pkg.sv | 10 +
 rtl/frobenius_sumsq_sqrt_if.sv | 15 +
 rtl/frobenius_sumsq_sqrt_isqrt_seq.sv | 47 ++++
 rtl/frobenius_sumsq_sqrt.sv | 54 +++++
 tb/tb_frobenius_sumsq_sqrt.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/frobenius_sumsq_sqrt_pkg.sv
// frob_pkg: shared state encoding and width helpers for the Frobenius norm path
package frob_pkg;
  typedef enum logic [1:0] {ACCUM, SQRT, OUT} state_e;
  function automatic int acc_w(input int data_w, input int n_elem);
    return 2 * data_w + $clog2(n_elem);
  endfunction
  function automatic int root_w(input int data_w, input int n_elem);
    return (acc_w(data_w, n_elem) + 1) / 2;
  endfunction
endpackage

// File: rtl/frobenius_sumsq_sqrt_if.sv
// frobenius_sumsq_sqrt_if: element input stream and norm output stream
interface frobenius_sumsq_sqrt_if #(parameter int DATA_W = 16, parameter int N_ELEM = 1024);
  import frob_pkg::*;
  localparam int ACC_W = acc_w(DATA_W, N_ELEM);
  localparam int ROOT_W = root_w(DATA_W, N_ELEM);
  logic valid_in;
  logic ready_in;
  logic signed [DATA_W-1:0] input_data;
  logic valid_out;
  logic ready_out;
  logic [ROOT_W-1:0] norm_out;
  logic [ACC_W-1:0] sumsq_out;
  modport master (output valid_in, input_data, ready_out, input ready_in, valid_out, norm_out, sumsq_out);
  modport slave (input valid_in, input_data, ready_out, output ready_in, valid_out, norm_out, sumsq_out);
endinterface

// File: rtl/frobenius_sumsq_sqrt_isqrt_seq.sv
// isqrt_seq: restoring square root, one result bit per cycle, MSB first
module isqrt_seq #(parameter int ACC_W = 34, parameter int ROOT_W = 17) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ACC_W-1:0]  x_i,
  output logic              done_o,
  output logic [ROOT_W-1:0] root_o
);
  localparam int XW = 2 * ROOT_W;
  localparam int IW = ROOT_W > 1 ? $clog2(ROOT_W) : 1;
  logic [XW-1:0] x_q, x_d;
  logic [ROOT_W-1:0] rem_q, rem_d, root_q, root_d;
  logic [IW-1:0] iter_q, iter_d;
  logic busy_q, busy_d;
  logic [ROOT_W+1:0] rem_sh, trial;
  logic ge;
  // bring down two operand bits, subtract the trial divisor when it fits
  always_comb begin
    rem_sh = {rem_q, x_q[XW-1 -: 2]};
    trial = {root_q, 2'b01};
    ge = rem_sh >= trial;
    done_o = busy_q && iter_q == '0;
    x_d = start_i ? XW'(x_i) : busy_q ? {x_q[XW-3:0], 2'b00} : x_q;
    rem_d = start_i ? '0 : busy_q ? ROOT_W'(ge ? rem_sh - trial : rem_sh) : rem_q;
    root_d = start_i ? '0 : busy_q ? {root_q[ROOT_W-2:0], ge} : root_q;
    iter_d = start_i ? IW'(ROOT_W - 1) : busy_q ? iter_q - IW'(1) : iter_q;
    busy_d = start_i || (busy_q && !done_o);
  end
  // iteration state
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      rem_q <= '0;
      root_q <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      x_q <= x_d;
      rem_q <= rem_d;
      root_q <= root_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end
  assign root_o = root_q;
endmodule

// File: rtl/frobenius_sumsq_sqrt.sv
// frobenius_sumsq_sqrt: per-frame sum of squares and its floor square root
module frobenius_sumsq_sqrt import frob_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int N_ELEM = 1024
) (
  input logic clk,
  input logic rst,
  frobenius_sumsq_sqrt_if.slave bus
);
  localparam int ACC_W = acc_w(DATA_W, N_ELEM);
  localparam int ROOT_W = root_w(DATA_W, N_ELEM);
  localparam int CW = N_ELEM > 1 ? $clog2(N_ELEM) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DATA_W-1:0] ext, sq;
  logic accept, last, hs, done;
  logic [ROOT_W-1:0] root;
  // frame FSM: accumulate squares, hand the total to the root unit, hold result
  always_comb begin
    bus.ready_in = state_q == ACCUM && !rst;
    bus.valid_out = state_q == OUT;
    ext = (2 * DATA_W)'(bus.input_data);
    sq = ext * ext;
    accept = bus.valid_in && bus.ready_in;
    last = accept && cnt_q == CW'(N_ELEM - 1);
    hs = bus.valid_out && bus.ready_out;
    acc_d = hs ? '0 : accept ? acc_q + ACC_W'($unsigned(sq)) : acc_q;
    cnt_d = accept ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    state_d = last ? SQRT : (state_q == SQRT && done) ? OUT : hs ? ACCUM : state_q;
  end
  // frame state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
  isqrt_seq #(.ACC_W(ACC_W), .ROOT_W(ROOT_W)) u_isqrt (
    .clk(clk),
    .rst(rst),
    .start_i(last),
    .x_i(acc_d),
    .done_o(done),
    .root_o(root)
  );
  assign bus.norm_out = root;
  assign bus.sumsq_out = acc_q;
endmodule

// File: tb/tb_frobenius_sumsq_sqrt.sv
// tb_frobenius_sumsq_sqrt: directed and random frames checked against an arithmetic model
module tb_frobenius_sumsq_sqrt;
  localparam int DATA_W = 16;
  localparam int N_ELEM = 4;
  localparam int ROOT_W = 17;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int frame [N_ELEM];
  always #5 clk = ~clk;
  frobenius_sumsq_sqrt_if #(.DATA_W(DATA_W), .N_ELEM(N_ELEM)) bus ();
  frobenius_sumsq_sqrt #(.DATA_W(DATA_W), .N_ELEM(N_ELEM)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic longint ref_sumsq();
    longint s = 0;
    for (int i = 0; i < N_ELEM; i++) s += longint'(frame[i]) * longint'(frame[i]);
    return s;
  endfunction
  function automatic longint ref_norm(input longint s);
    longint r = longint'($floor($sqrt(real'(s))));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction
  task automatic send(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int tries = 0;
      logic took;
      repeat ($urandom_range(gap, 0)) step();
      bus.valid_in = 1'b1;
      bus.input_data = 16'(frame[i]);
      do begin
        took = bus.ready_in;
        step();
        tries++;
      end while (!took && tries < 50);
      if (!took) chk("accept_timeout", 0, 1);
      bus.valid_in = 1'b0;
    end
  endtask
  task automatic expect_frame(input string tag);
    longint s = ref_sumsq();
    int lat = 0;
    while (!bus.valid_out && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, ROOT_W);
    chk({tag, "_sumsq"}, bus.sumsq_out, s);
    chk({tag, "_norm"}, bus.norm_out, ref_norm(s));
  endtask
  task automatic handshake(input string tag);
    bus.ready_out = 1'b1;
    step();
    bus.ready_out = 1'b0;
    chk({tag, "_valid_drop"}, bus.valid_out, 0);
    chk({tag, "_ready_back"}, bus.ready_in, 1);
  endtask
  initial begin
    longint s;
    logic seen;
    bus.valid_in = 1'b0;
    bus.input_data = '0;
    bus.ready_out = 1'b0;
    repeat (3) step();
    chk("rst_ready_in", bus.ready_in, 0);
    chk("rst_valid_out", bus.valid_out, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_in", bus.ready_in, 1);
    chk("post_rst_norm", bus.norm_out, 0);
    chk("post_rst_sumsq", bus.sumsq_out, 0);
    frame = '{3, 4, 0, 0};
    send(4, 0);
    expect_frame("f3400");
    handshake("f3400");
    frame = '{-3, -4, 0, 0};
    send(4, 0);
    expect_frame("fneg34");
    handshake("fneg34");
    frame = '{1, 1, 1, 0};
    send(4, 0);
    expect_frame("f1110");
    handshake("f1110");
    frame = '{0, 0, 0, 0};
    send(4, 0);
    expect_frame("fzero");
    handshake("fzero");
    frame = '{-32768, -32768, -32768, -32768};
    send(4, 0);
    expect_frame("fmin");
    chk("fmin_sumsq_const", bus.sumsq_out, 64'd4294967296);
    chk("fmin_norm_const", bus.norm_out, 65536);
    handshake("fmin");
    frame = '{7, 1, 2, 3};
    send(4, 0);
    expect_frame("fstall");
    s = ref_sumsq();
    for (int i = 0; i < 10; i++) begin
      bus.valid_in = i[0];
      bus.input_data = 16'd100;
      step();
      chk("stall_valid_out", bus.valid_out, 1);
      chk("stall_ready_in", bus.ready_in, 0);
      chk("stall_sumsq", bus.sumsq_out, s);
      chk("stall_norm", bus.norm_out, ref_norm(s));
    end
    bus.valid_in = 1'b0;
    handshake("fstall");
    frame = '{3, 4, 0, 0};
    send(4, 0);
    expect_frame("after_stall");
    handshake("after_stall");
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N_ELEM; i++) frame[i] = int'($signed(16'($urandom)));
      send(4, 3);
      expect_frame($sformatf("rand%0d", f));
      handshake($sformatf("rand%0d", f));
    end
    frame = '{9, 9, 0, 0};
    send(2, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midframe_rst_valid_out", bus.valid_out, 0);
    chk("midframe_rst_ready_in", bus.ready_in, 1);
    frame = '{3, 4, 0, 0};
    send(4, 0);
    expect_frame("after_midframe_rst");
    handshake("after_midframe_rst");
    frame = '{100, 100, 100, 100};
    send(4, 0);
    repeat (5) step();
    chk("midsqrt_busy_valid_out", bus.valid_out, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midsqrt_rst_ready_in", bus.ready_in, 1);
    seen = 1'b0;
    repeat (25) begin
      step();
      seen |= bus.valid_out;
    end
    chk("midsqrt_rst_no_output", seen, 0);
    frame = '{3, 4, 0, 0};
    send(4, 0);
    expect_frame("after_midsqrt_rst");
    handshake("after_midsqrt_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
